mac32_arbiter: RTL

Round-robin scheduler sharing one fixed-latency, fully pipelined mac32 datapath (Result = A + B*C, IEEE-754 single) between NUM_REQ requesters. Accepts one operand triple per cycle via per-requester valid/ready, issues it to the MAC, tags it in a latency-matched shift register, and returns results in issue order through a credit-protected response FIFO. Sits between the requesting engines and the mac32 instance.

---
 rtl/mac32_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mac32_arbiter.sv
// Round-robin front end for one shared, fixed-latency pipelined MAC: grants one operand
// triple per cycle, tracks issued ops by tag, and returns results in issue order.
module mac32_arbiter #(
  parameter int unsigned PARM_XLEN   = 32,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAC_LATENCY = 3,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*PARM_XLEN-1:0]   req_A_i,
  input  logic [NUM_REQ*PARM_XLEN-1:0]   req_B_i,
  input  logic [NUM_REQ*PARM_XLEN-1:0]   req_C_i,
  output logic                           mac_valid_o,
  output logic [PARM_XLEN-1:0]           mac_A_o,
  output logic [PARM_XLEN-1:0]           mac_B_o,
  output logic [PARM_XLEN-1:0]           mac_C_o,
  input  logic [PARM_XLEN-1:0]           mac_Result_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic [PARM_XLEN-1:0]           rsp_Result_o,
  output logic                           idle_o
);

  localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [ID_W-1:0]      last_grant_q;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [ID_W-1:0]      grant_id, cand;
  logic                 grant_found, credit, accept;
  logic [PARM_XLEN-1:0] sel_a, sel_b, sel_c;

  logic                 mac_valid_q;
  logic [PARM_XLEN-1:0] mac_a_q, mac_b_q, mac_c_q;

  logic [MAC_LATENCY:0]           tag_vld_q;
  logic [MAC_LATENCY:0][ID_W-1:0] tag_id_q;

  logic [ID_W-1:0]      fid_q  [RSP_DEPTH];
  logic [PARM_XLEN-1:0] fres_q [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]     fcnt_q, fcnt_d;
  logic                 push, pop, fifo_nonempty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == RSP_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_c       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == grant_id) begin
        sel_a = req_A_i[k*PARM_XLEN +: PARM_XLEN];
        sel_b = req_B_i[k*PARM_XLEN +: PARM_XLEN];
        sel_c = req_C_i[k*PARM_XLEN +: PARM_XLEN];
      end
    end
  end

  assign credit = (occ_q < OCC_W'(RSP_DEPTH));
  assign accept = grant_found & credit;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_id] = 1'b1;
  end

  assign fifo_nonempty = (fcnt_q != '0);
  assign push          = tag_vld_q[MAC_LATENCY];
  assign pop           = fifo_nonempty & rsp_ready_i;

  always_comb begin
    occ_d = occ_q;
    if (accept && !pop)      occ_d = occ_q + 1'b1;
    else if (!accept && pop) occ_d = occ_q - 1'b1;
    fcnt_d = fcnt_q;
    if (push && !pop)        fcnt_d = fcnt_q + 1'b1;
    else if (!push && pop)   fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      occ_q        <= '0;
      mac_valid_q  <= 1'b0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_c_q      <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
    end else begin
      occ_q       <= occ_d;
      mac_valid_q <= accept;
      if (accept) begin
        last_grant_q <= grant_id;
        mac_a_q      <= sel_a;
        mac_b_q      <= sel_b;
        mac_c_q      <= sel_c;
      end
      // Tail stage lines up with mac_Result_i for the op issued MAC_LATENCY+1 edges ago.
      tag_vld_q <= {tag_vld_q[MAC_LATENCY-1:0], accept};
      tag_id_q  <= {tag_id_q[MAC_LATENCY-1:0], grant_id};
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fid_q[wr_ptr_q]  <= tag_id_q[MAC_LATENCY];
      fres_q[wr_ptr_q] <= mac_Result_i;
    end
  end

  assign mac_valid_o  = mac_valid_q;
  assign mac_A_o      = mac_a_q;
  assign mac_B_o      = mac_b_q;
  assign mac_C_o      = mac_c_q;
  assign rsp_valid_o  = fifo_nonempty;
  assign rsp_id_o     = fifo_nonempty ? fid_q[rd_ptr_q]  : '0;
  assign rsp_Result_o = fifo_nonempty ? fres_q[rd_ptr_q] : '0;
  assign idle_o       = (occ_q == '0);

endmodule
